// File: rtl/clock_time_ctrl_if.sv
// Handshake bundle between the watch time-keeping controller and its neighbours:
// tick/button pulses in, divider control and time/display state out.
interface clock_time_ctrl_if;
    logic       sec_tick;
    logic       blink_tick;
    logic       btn_mode;
    logic       btn_inc;
    logic       div_en;
    logic       div_rst;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] field_sel;
    logic       blink;
    logic       sec_pulse;

    modport master (
        output sec_tick, blink_tick, btn_mode, btn_inc,
        input  div_en, div_rst, hours, minutes, seconds, field_sel, blink, sec_pulse
    );

    modport slave (
        input  sec_tick, blink_tick, btn_mode, btn_inc,
        output div_en, div_rst, hours, minutes, seconds, field_sel, blink, sec_pulse
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// Watch time-keeping controller: runs hh:mm:ss from the 1 Hz tick, sequences the
// 1 Hz divider, and lets the user set hours/minutes through a three-state mode FSM.
module clock_time_ctrl #(
    parameter int unsigned HOUR_MOD = 24
) (
    input  logic               clock,
    input  logic               reset,
    clock_time_ctrl_if.slave   bus
);
    localparam int unsigned HW = 5;
    localparam int unsigned MW = 6;
    localparam int unsigned SW = 6;
    localparam logic [HW-1:0] HOUR_MAX = HW'(HOUR_MOD - 1);
    localparam logic [MW-1:0] MIN_MAX  = MW'(59);
    localparam logic [SW-1:0] SEC_MAX  = SW'(59);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [HW-1:0]   r_hours, w_hours_nxt;
    logic [MW-1:0]   r_minutes, w_minutes_nxt;
    logic [SW-1:0]   r_seconds, w_seconds_nxt;
    logic [1:0]      r_field_sel, w_field_sel_nxt;
    logic            r_blink, w_blink_nxt;
    logic            r_sec_pulse, w_sec_pulse_nxt;
    logic            r_div_en, w_div_en_nxt;
    logic            r_div_rst, w_div_rst_nxt;
    logic            w_state_chg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:      if (bus.btn_mode) w_state_nxt = SET_HOUR;
            SET_HOUR: if (bus.btn_mode) w_state_nxt = SET_MIN;
            SET_MIN:  if (bus.btn_mode) w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);

    // Next values of every registered output; btn_mode masks btn_inc in the set states.
    always_comb begin
        w_hours_nxt     = r_hours;
        w_minutes_nxt   = r_minutes;
        w_seconds_nxt   = r_seconds;
        w_sec_pulse_nxt = 1'b0;
        w_div_rst_nxt   = 1'b0;
        w_div_en_nxt    = (w_state_nxt == RUN);
        w_blink_nxt     = 1'b0;
        case (w_state_nxt)
            SET_HOUR: w_field_sel_nxt = 2'b01;
            SET_MIN:  w_field_sel_nxt = 2'b10;
            default:  w_field_sel_nxt = 2'b00;
        endcase

        if (!w_state_chg && r_state != RUN)
            w_blink_nxt = bus.blink_tick ? ~r_blink : r_blink;

        case (r_state)
            RUN: begin
                if (bus.sec_tick) begin
                    w_sec_pulse_nxt = 1'b1;
                    if (r_seconds == SEC_MAX) begin
                        w_seconds_nxt = '0;
                        if (r_minutes == MIN_MAX) begin
                            w_minutes_nxt = '0;
                            w_hours_nxt   = (r_hours == HOUR_MAX) ? '0 : r_hours + HW'(1);
                        end else begin
                            w_minutes_nxt = r_minutes + MW'(1);
                        end
                    end else begin
                        w_seconds_nxt = r_seconds + SW'(1);
                    end
                end
            end
            SET_HOUR: begin
                if (!bus.btn_mode && bus.btn_inc)
                    w_hours_nxt = (r_hours == HOUR_MAX) ? '0 : r_hours + HW'(1);
            end
            SET_MIN: begin
                if (bus.btn_mode) begin
                    w_seconds_nxt = '0;
                    w_div_rst_nxt = 1'b1;
                end else if (bus.btn_inc) begin
                    w_minutes_nxt = (r_minutes == MIN_MAX) ? '0 : r_minutes + MW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hours     <= '0;
            r_minutes   <= '0;
            r_seconds   <= '0;
            r_field_sel <= 2'b00;
            r_blink     <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_div_en    <= 1'b0;
            r_div_rst   <= 1'b1;
        end else begin
            r_hours     <= w_hours_nxt;
            r_minutes   <= w_minutes_nxt;
            r_seconds   <= w_seconds_nxt;
            r_field_sel <= w_field_sel_nxt;
            r_blink     <= w_blink_nxt;
            r_sec_pulse <= w_sec_pulse_nxt;
            r_div_en    <= w_div_en_nxt;
            r_div_rst   <= w_div_rst_nxt;
        end
    end

    assign bus.hours     = r_hours;
    assign bus.minutes   = r_minutes;
    assign bus.seconds   = r_seconds;
    assign bus.field_sel = r_field_sel;
    assign bus.blink     = r_blink;
    assign bus.sec_pulse = r_sec_pulse;
    assign bus.div_en    = r_div_en;
    assign bus.div_rst   = r_div_rst;
endmodule

// File: doc/clock_time_ctrl.md
# clock_time_ctrl

Time-keeping controller for the watch datapath. Consumes the 1 Hz tick from the main tick divider, sequences that divider (enable and restart), and maintains the hours/minutes/seconds registers. A three-state mode FSM lets the user set hours and minutes from two pre-debounced button pulses, and drives a blink flag for the display field being edited.

## Interface
- HOUR_MOD, 24: hours count 0..HOUR_MOD-1; legal values 12 or 24.

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- sec_tick  in  1  one-cycle pulse from the 1 Hz divider
- blink_tick  in  1  one-cycle pulse from a ~2 Hz divider; drives blink toggling
- btn_mode  in  1  one-cycle pulse, debounced; advances mode
- btn_inc  in  1  one-cycle pulse, debounced; increments field being set
- div_en  out  1  enable to the 1 Hz divider
- div_rst  out  1  synchronous restart to the 1 Hz divider
- hours  out  5  current hours, binary
- minutes  out  6  current minutes, binary
- seconds  out  6  current seconds, binary
- field_sel  out  2  00 = run, 01 = hours selected, 10 = minutes selected
- blink  out  1  1 = blank the selected field; always 0 in RUN
- sec_pulse  out  1  one-cycle pulse each time seconds advance in RUN

## Operation
- FSM states: RUN, SET_HOUR, SET_MIN. btn_mode transitions: RUN -> SET_HOUR -> SET_MIN -> RUN.
- RUN
  - div_en = 1 and div_rst = 0.
  - On sec_tick: seconds +1, and sec_pulse = 1 for one cycle.
  - Seconds 59 -> 0 carries into minutes; minutes 59 -> 0 carries into hours.
  - Hours HOUR_MOD-1 -> 0.
  - All carries resolve in the same cycle, so 23:59:59 -> 00:00:00 in one update.
- SET_HOUR
  - div_en = 0; sec_tick is ignored.
  - btn_inc: hours +1 mod HOUR_MOD. There is no carry into other fields.
- SET_MIN
  - div_en = 0.
  - btn_inc: minutes +1 mod 60. There is no carry into hours.
- Leaving SET_MIN (btn_mode):
  - seconds <= 0.
  - div_rst = 1 for exactly one cycle, so the first second after setting is a full second.
  - The state returns to RUN.
- blink
  - Cleared on any state change.
  - In SET_HOUR or SET_MIN, toggles on each blink_tick.
  - Forced to 0 in RUN.
- Simultaneous events
  - RUN, sec_tick with btn_mode: the tick is applied and the state moves to SET_HOUR in the same edge.
  - SET_*, btn_mode with btn_inc: the mode change wins and btn_inc is dropped.
  - blink_tick with a state change: blink = 0.
- Width rule: every increment wraps by compare-to-max, never by natural overflow. Values outside the range are unreachable from reset.

## Timing
- All outputs are registered. A response to an input pulse sampled at edge N is visible after edge N; there is one cycle of latency.
- Reset values (asynchronous, while reset = 1):
  - state RUN
  - hours, minutes, seconds, field_sel, blink, sec_pulse = 0
  - div_en = 0
  - div_rst = 1
- First edge after reset release: div_en = 1, div_rst = 0.
- Reset mid-operation (any state, any edit) returns to the reset values immediately. Any in-progress edit is lost.
- div_en falls on the same edge that enters SET_HOUR.
- On the edge that enters RUN from SET_MIN, div_rst = 1, div_en = 1, and seconds = 0. On the following edge, div_rst returns to 0.
- sec_pulse is high only on the cycle after the sec_tick sample, and only in RUN.

## Test plan
- Reset release, then 61 sec_tick pulses: seconds = 1, minutes = 1, hours = 0; sec_pulse asserts 61 times; div_en = 1 from the first edge after reset.
- Preload by setting 23:59, return to RUN, send 59 ticks and then 1 more: the time reads 00:00:00 after the last tick, with every field wrapping in one cycle.
- btn_mode, then 25 btn_inc: hours = 1; field_sel = 01; div_en = 0; sec_tick pulses leave seconds unchanged. Repeat with HOUR_MOD = 12 and 13 btn_inc: hours = 1.
- From SET_MIN with seconds = 37, press btn_mode: seconds = 0, div_rst high for exactly 1 cycle, field_sel = 00, div_en = 1.
- Apply sec_tick and btn_mode in the same cycle in RUN: seconds +1, state SET_HOUR. Apply btn_mode and btn_inc together in SET_HOUR: state SET_MIN, hours unchanged.
- Assert reset asynchronously (between edges) while in SET_MIN with blink = 1: all outputs take their reset values before the next edge; div_rst = 1.
